// File: rtl/bsg_util_link_pkg.sv
// Shared definitions for the GPIO util-link master: flit field layout,
// the buffered request record and the packet FSM states.
package bsg_util_link_pkg;

  // Request fields are stored at a fixed maximum width; modules use the low bits.
  localparam int max_cord_width_lp = 16;
  localparam int max_sel_width_lp  = 16;

  localparam int hdr_cord_offset_lp = 0;
  localparam int hdr_len_value_lp   = 1;
  localparam int pld_sel_offset_lp  = 0;

  typedef struct packed {
    logic [max_cord_width_lp-1:0] dest_cord;
    logic [max_sel_width_lp-1:0]  sel;
    logic                         val;
  } gpio_req_s;

  typedef enum logic [1:0] {
    eIdle,
    eHeader,
    ePayload
  } gpio_master_state_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous reset to a configurable value.
module bsg_dff_reset_en #(
  parameter int                 width_p     = 8,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] r_data;

  assign data_o = r_data;

  always_ff @(posedge clk_i) begin
    if (reset_i)   r_data <= reset_val_p;
    else if (en_i) r_data <= data_i;
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with valid/ready enqueue and valid/yumi dequeue.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rd_ptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) r_wr_ptr <= ~r_wr_ptr;
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bsg_util_link_gpio_master.sv
// Buffers single-bit GPIO writes and sends each as a header+payload packet,
// keeping a shadow of the remote GPIO register to skip redundant writes.
module bsg_util_link_gpio_master
  import bsg_util_link_pkg::*;
#(
  parameter int  flit_width_p     = 16,
  parameter int  num_gpio_p       = 8,
  parameter int  cord_width_p     = 4,
  parameter int  len_width_p      = 4,
  parameter bit  skip_redundant_p = 1'b1,
  localparam int lg_num_gpio_lp   = (num_gpio_p > 1) ? $clog2(num_gpio_p) : 1,
  localparam int link_width_lp    = flit_width_p + 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [cord_width_p-1:0]   dest_cord_i,
  input  logic [lg_num_gpio_lp-1:0] sel_i,
  input  logic                      val_i,
  input  logic [link_width_lp-1:0]  link_i,
  output logic [link_width_lp-1:0]  link_o,
  output logic [num_gpio_p-1:0]     gpio_shadow_o,
  output logic                      idle_o,
  output logic                      error_o
);

  gpio_req_s                 w_enq_req;
  gpio_req_s                 w_head;
  logic                      w_fifo_v;
  logic                      w_yumi;
  logic                      w_link_ready;
  logic                      w_sel_bad;
  logic                      w_redundant;
  logic                      w_shadow_en;
  logic [lg_num_gpio_lp-1:0] w_head_sel;
  logic [cord_width_p-1:0]   w_head_cord;
  logic                      w_head_val;
  logic [flit_width_p-1:0]   w_header;
  logic [flit_width_p-1:0]   w_payload;
  logic [num_gpio_p-1:0]     w_shadow;
  logic [num_gpio_p-1:0]     w_shadow_next;
  logic                      w_unused;

  gpio_master_state_e      r_state;
  logic                    r_link_v;
  logic [flit_width_p-1:0] r_link_data;
  logic                    r_error;

  always_comb begin
    w_enq_req                                = '0;
    w_enq_req.dest_cord[cord_width_p-1:0]    = dest_cord_i;
    w_enq_req.sel[lg_num_gpio_lp-1:0]        = sel_i;
    w_enq_req.val                            = val_i;
  end

  bsg_two_fifo #(
    .width_p($bits(gpio_req_s))
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .ready_o(ready_o),
    .data_i (w_enq_req),
    .v_i    (v_i),
    .v_o    (w_fifo_v),
    .data_o (w_head),
    .yumi_i (w_yumi)
  );

  assign w_head_sel   = w_head.sel[lg_num_gpio_lp-1:0];
  assign w_head_cord  = w_head.dest_cord[cord_width_p-1:0];
  assign w_head_val   = w_head.val;
  assign w_link_ready = link_i[0];
  assign w_unused     = ^{link_i[link_width_lp-1:1], w_head};

  // Out-of-range selects exist only when num_gpio_p is not a power of two.
  assign w_sel_bad   = ({1'b0, w_head_sel} >= (lg_num_gpio_lp+1)'(num_gpio_p));
  assign w_redundant = skip_redundant_p && !w_sel_bad && (w_shadow[w_head_sel] == w_head_val);

  always_comb begin
    w_header                                          = '0;
    w_header[hdr_cord_offset_lp +: cord_width_p]      = w_head_cord;
    w_header[cord_width_p +: len_width_p]             = len_width_p'(hdr_len_value_lp);
    w_payload                                         = '0;
    w_payload[pld_sel_offset_lp +: lg_num_gpio_lp]    = w_head_sel;
    w_payload[flit_width_p-1]                         = w_head_val;
  end

  always_comb begin
    w_shadow_next = w_shadow;
    if (!w_sel_bad) w_shadow_next[w_head_sel] = w_head_val;
  end

  // The head entry stays queued until its payload handshakes, so it drives both flits.
  assign w_shadow_en = (r_state == ePayload) && w_link_ready;
  assign w_yumi      = ((r_state == eIdle) && w_fifo_v && (w_sel_bad || w_redundant)) || w_shadow_en;

  bsg_dff_reset_en #(
    .width_p    (num_gpio_p),
    .reset_val_p({num_gpio_p{1'b1}})
  ) u_shadow (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (w_shadow_en),
    .data_i (w_shadow_next),
    .data_o (w_shadow)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= eIdle;
      r_link_v    <= 1'b0;
      r_link_data <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        eIdle: begin
          if (w_fifo_v) begin
            if (w_sel_bad) begin
              r_error <= 1'b1;
            end else if (!w_redundant) begin
              r_state     <= eHeader;
              r_link_v    <= 1'b1;
              r_link_data <= w_header;
            end
          end
        end
        eHeader: begin
          if (w_link_ready) begin
            r_state     <= ePayload;
            r_link_data <= w_payload;
          end
        end
        ePayload: begin
          if (w_link_ready) begin
            r_state     <= eIdle;
            r_link_v    <= 1'b0;
            r_link_data <= '0;
          end
        end
        default: begin
          r_state  <= eIdle;
          r_link_v <= 1'b0;
        end
      endcase
    end
  end

  assign link_o        = {r_link_v, r_link_data, 1'b1};
  assign gpio_shadow_o = w_shadow;
  assign idle_o        = !w_fifo_v && (r_state == eIdle);
  assign error_o       = r_error;

endmodule

// File: tb/tb_bsg_util_link_gpio_master.sv
// Scoreboard bench: an 8-GPIO master and a 6-GPIO master, random and directed requests,
// expected flits queued at request acceptance and popped by an independent link monitor.
module tb_bsg_util_link_gpio_master;

  typedef struct {
    int dest;
    int sel;
    int val;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vIn [2];
  logic        readyOut [2];
  logic [3:0]  destIn [2];
  logic [2:0]  selIn [2];
  logic        valIn [2];
  logic [17:0] linkI;
  logic [17:0] linkO [2];
  logic [7:0]  shadow8;
  logic [5:0]  shadow6;
  logic        idleOut [2];
  logic        errOut [2];
  logic        downReady = 1'b1;

  int          readyMode = 0;
  int          checks = 0;
  int          passes = 0;
  int          hsCount [2];
  int          numGpio [2];
  bit          modelShadow [2][8];
  bit          modelErr [2];
  logic [15:0] expQ0 [$];
  logic [15:0] expQ1 [$];
  req_t        pending [$];
  bit          sawNotReady;
  bit          prevStall [2];
  logic [15:0] prevData [2];

  assign linkI = {17'b0, downReady};

  always #5 clk = ~clk;

  bsg_util_link_gpio_master #(
    .flit_width_p(16), .num_gpio_p(8), .cord_width_p(4), .len_width_p(4), .skip_redundant_p(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .v_i(vIn[0]), .ready_o(readyOut[0]),
    .dest_cord_i(destIn[0]), .sel_i(selIn[0]), .val_i(valIn[0]),
    .link_i(linkI), .link_o(linkO[0]), .gpio_shadow_o(shadow8),
    .idle_o(idleOut[0]), .error_o(errOut[0])
  );

  bsg_util_link_gpio_master #(
    .flit_width_p(16), .num_gpio_p(6), .cord_width_p(4), .len_width_p(4), .skip_redundant_p(1'b1)
  ) dut6 (
    .clk_i(clk), .reset_i(reset), .v_i(vIn[1]), .ready_o(readyOut[1]),
    .dest_cord_i(destIn[1]), .sel_i(selIn[1]), .val_i(valIn[1]),
    .link_i(linkI), .link_o(linkO[1]), .gpio_shadow_o(shadow6),
    .idle_o(idleOut[1]), .error_o(errOut[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 'h%0h, required 'h%0h at %0t", name, actual, expected, $time);
  endtask

  function automatic void pushExp(input int k, input logic [15:0] flit);
    if (k == 0) expQ0.push_back(flit);
    else        expQ1.push_back(flit);
  endfunction

  function automatic int expSize(input int k);
    return (k == 0) ? expQ0.size() : expQ1.size();
  endfunction

  function automatic logic [15:0] popExp(input int k);
    return (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
  endfunction

  function automatic logic [7:0] getShadow(input int k);
    return (k == 0) ? shadow8 : {2'b11, shadow6};
  endfunction

  function automatic logic [7:0] modelVec(input int k);
    logic [7:0] vec;
    vec = 8'hFF;
    for (int i = 0; i < numGpio[k]; i++) vec[i] = modelShadow[k][i];
    return vec;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) modelShadow[k][i] = 1'b1;
      modelErr[k] = 1'b0;
    end
    expQ0.delete();
    expQ1.delete();
  endfunction

  // A write either flags an error, is dropped as redundant, or becomes two flits.
  function automatic void modelAccept(input int k, input req_t r);
    if (r.sel >= numGpio[k]) begin
      modelErr[k] = 1'b1;
    end else if (int'(modelShadow[k][r.sel]) != r.val) begin
      pushExp(k, 16'(32'h10 | r.dest));
      pushExp(k, 16'(r.sel | (r.val << 15)));
      modelShadow[k][r.sel] = (r.val != 0);
    end
  endfunction

  task automatic applyReset();
    @(posedge clk); #1;
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives every pending request back-to-back on instance k, holding v high between them.
  task automatic applyStimulus(input int k);
    req_t r;
    int   guard;
    @(posedge clk); #1;
    while (pending.size() > 0) begin
      r         = pending.pop_front();
      destIn[k] = 4'(r.dest);
      selIn[k]  = 3'(r.sel);
      valIn[k]  = (r.val != 0);
      vIn[k]    = 1'b1;
      guard     = 0;
      @(negedge clk);
      while (!readyOut[k] && guard < 100) begin
        sawNotReady = 1'b1;
        guard++;
        @(negedge clk);
      end
      checks++;
      if (guard >= 100) begin
        $display("[TB] FAIL acceptTimeout%0d: got ready_o=0 for 100 cycles, required 1", k);
        pending.delete();
      end else begin
        passes++;
        modelAccept(k, r);
      end
      @(posedge clk); #1;
    end
    vIn[k] = 1'b0;
  endtask

  task automatic waitV(input int k);
    int g;
    g = 0;
    @(negedge clk);
    while (!linkO[k][17] && g < 50) begin
      g++;
      @(negedge clk);
    end
    checks++;
    if (g >= 50) $display("[TB] FAIL waitValid%0d: got link_o.v=0 for 50 cycles, required 1", k);
    else passes++;
  endtask

  task automatic waitIdle(input int k);
    int g;
    g = 0;
    @(negedge clk);
    while (!(idleOut[k] && expSize(k) == 0) && g < 500) begin
      g++;
      @(negedge clk);
    end
    checks++;
    if (g >= 500) $display("[TB] FAIL idleTimeout%0d: got idle=%0b pending=%0d, required idle with 0 pending",
                           k, idleOut[k], expSize(k));
    else passes++;
  endtask

  task automatic checkState(input int k);
    checkOutput($sformatf("shadow%0d", k), 32'(getShadow(k)), 32'(modelVec(k)));
    checkOutput($sformatf("error%0d", k), 32'(errOut[k]), 32'(modelErr[k]));
  endtask

  // Downstream ready generator; in mode 2 the directed tests drive it themselves.
  initial forever begin
    @(posedge clk); #1;
    if (readyMode == 1)      downReady = ($urandom_range(0, 3) != 0);
    else if (readyMode == 0) downReady = 1'b1;
  end

  // Link monitor: every handshake pops an expected flit; stalls must hold v and data.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        prevStall[k] = 1'b0;
      end else begin
        if (prevStall[k])
          checkOutput($sformatf("stallHold%0d", k), 32'(linkO[k][17:1]), 32'({1'b1, prevData[k]}));
        if (linkO[k][17] && downReady) begin
          hsCount[k]++;
          if (expSize(k) == 0) begin
            checks++;
            $display("[TB] FAIL flit%0d: got unexpected flit 'h%0h, required no flit", k, linkO[k][16:1]);
          end else begin
            checkOutput($sformatf("flit%0d", k), 32'(linkO[k][16:1]), 32'(popExp(k)));
          end
        end
        prevStall[k] = linkO[k][17] && !downReady;
        prevData[k]  = linkO[k][16:1];
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int k;
    int n;
    numGpio[0] = 8;
    numGpio[1] = 6;
    for (int i = 0; i < 2; i++) begin
      vIn[i] = 1'b0; destIn[i] = '0; selIn[i] = '0; valIn[i] = 1'b0;
      hsCount[i] = 0; prevStall[i] = 1'b0; prevData[i] = '0;
    end
    modelReset();

    // Reset state
    applyReset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("resetReady", 32'(readyOut[i]), 32'd1);
      checkOutput("resetIdle", 32'(idleOut[i]), 32'd1);
      checkOutput("resetLink", 32'(linkO[i][17:1]), 32'd0);
      checkOutput("resetShadow", 32'(getShadow(i)), 32'hFF);
      checkOutput("resetError", 32'(errOut[i]), 32'd0);
    end

    // Single write with exact latency
    pending.push_back('{3, 5, 0});
    applyStimulus(0);
    @(negedge clk);
    checkOutput("lat1Valid", 32'(linkO[0][17]), 32'd0);
    @(negedge clk);
    checkOutput("lat2Header", 32'(linkO[0][17:1]), 32'h10013);
    @(negedge clk);
    checkOutput("lat3Payload", 32'(linkO[0][17:1]), 32'h10005);
    @(negedge clk);
    checkOutput("lat4Valid", 32'(linkO[0][17]), 32'd0);
    checkOutput("lat4Shadow", 32'(shadow8), 32'hDF);
    checkOutput("lat4Idle", 32'(idleOut[0]), 32'd1);
    checkState(0);

    // Backpressure: 4 stall cycles on the header, 3 on the payload
    applyReset();
    readyMode = 2;
    downReady = 1'b0;
    base = hsCount[0];
    pending.push_back('{3, 5, 0});
    applyStimulus(0);
    waitV(0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 downReady = 1'b1;
    @(posedge clk); #1 downReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stallShadow", 32'(shadow8), 32'hFF);
    end
    @(posedge clk); #1 downReady = 1'b1;
    @(negedge clk);
    checkOutput("preHsShadow", 32'(shadow8), 32'hFF);
    @(negedge clk);
    checkOutput("postHsShadow", 32'(shadow8), 32'hDF);
    readyMode = 0;
    waitIdle(0);
    checkOutput("stallHandshakes", 32'(hsCount[0] - base), 32'd2);

    // Redundant write is dropped, differing write is sent
    applyReset();
    base = hsCount[0];
    pending.push_back('{1, 2, 1});
    applyStimulus(0);
    waitIdle(0);
    repeat (4) @(negedge clk);
    checkOutput("skipHandshakes", 32'(hsCount[0] - base), 32'd0);
    checkOutput("skipShadow", 32'(shadow8), 32'hFF);
    pending.push_back('{1, 2, 0});
    applyStimulus(0);
    waitIdle(0);
    checkOutput("writeShadow", 32'(shadow8), 32'hFB);
    checkOutput("writeHandshakes", 32'(hsCount[0] - base), 32'd2);

    // Out-of-range select on the 6-GPIO instance
    applyReset();
    base = hsCount[1];
    pending.push_back('{2, 7, 1});
    applyStimulus(1);
    waitIdle(1);
    checkOutput("badSelError", 32'(errOut[1]), 32'd1);
    checkOutput("badSelHandshakes", 32'(hsCount[1] - base), 32'd0);
    pending.push_back('{2, 1, 0});
    applyStimulus(1);
    waitIdle(1);
    checkOutput("errorSticky", 32'(errOut[1]), 32'd1);
    checkOutput("afterErrShadow", 32'(shadow6), 32'h3D);
    checkOutput("afterErrHandshakes", 32'(hsCount[1] - base), 32'd2);

    // Back-to-back requests fill the FIFO
    applyReset();
    base = hsCount[0];
    sawNotReady = 1'b0;
    pending.push_back('{0, 0, 0});
    pending.push_back('{5, 1, 0});
    pending.push_back('{9, 2, 0});
    applyStimulus(0);
    checkOutput("fifoFullReady", 32'(sawNotReady), 32'd1);
    waitIdle(0);
    checkOutput("burstHandshakes", 32'(hsCount[0] - base), 32'd6);
    checkOutput("burstShadow", 32'(shadow8), 32'hF8);

    // Reset while the payload is stalled
    applyReset();
    readyMode = 2;
    downReady = 1'b1;
    pending.push_back('{4, 6, 0});
    applyStimulus(0);
    waitV(0);
    @(posedge clk); #1 downReady = 1'b0;
    @(negedge clk);
    checkOutput("midPayload", 32'(linkO[0][17:1]), 32'h10006);
    @(posedge clk); #1 reset = 1'b1;
    modelReset();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midResetValid", 32'(linkO[0][17]), 32'd0);
    checkOutput("midResetShadow", 32'(shadow8), 32'hFF);
    checkOutput("midResetIdle", 32'(idleOut[0]), 32'd1);
    readyMode = 0;
    pending.push_back('{7, 3, 0});
    applyStimulus(0);
    waitIdle(0);
    checkOutput("afterResetShadow", 32'(shadow8), 32'hF7);

    // Randomized traffic on both instances with random backpressure
    applyReset();
    readyMode = 1;
    for (int it = 0; it < 120; it++) begin
      k = $urandom_range(0, 1);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++)
        pending.push_back('{int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1))});
      applyStimulus(k);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
    end
    waitIdle(0);
    waitIdle(1);
    checkState(0);
    checkState(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bsg_util_link_gpio_master.md
Name: bsg_util_link_gpio_master

Overview:
- Upstream partner of the GPIO util-link endpoint.
- Accepts single-bit GPIO write requests (destination cord, GPIO index, value) on a valid/ready interface and buffers them.
- Serializes each request into a 2-flit packet (header flit, then payload flit) on a bsg_ready_and_link_sif output.
- Keeps a shadow copy of the remote GPIO register, so firmware-side logic can read back state and skip redundant writes.

Parameters:
- flit_width_p, "inv", link flit width; must be >= max(cord_width_p+len_width_p, lg_num_gpio_lp+1).
- num_gpio_p, "inv", number of GPIOs at the remote endpoint.
- cord_width_p, "inv", width of destination coordinate in header flit.
- len_width_p, "inv", width of packet length field in header flit.
- skip_redundant_p, 1, when 1 a write whose value equals the shadow bit is retired without sending a packet.
- lg_num_gpio_lp (local), BSG_SAFE_CLOG2(num_gpio_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  request valid.
- ready_o  out  1  request accepted when v_i & ready_o.
- dest_cord_i  in  cord_width_p  destination cord for this request.
- sel_i  in  lg_num_gpio_lp  GPIO index.
- val_i  in  1  GPIO value to write.
- link_i  in  bsg_ready_and_link_sif_width(flit_width_p)  from downstream; only ready_and_rev is used.
- link_o  out  same  to downstream; v/data carry flits, ready_and_rev tied 1.
- gpio_shadow_o  out  num_gpio_p  mirror of remote GPIO state.
- idle_o  out  1  FIFO empty and FSM in eIdle.
- error_o  out  1  sticky; set when a request has sel_i >= num_gpio_p.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - FSM = eIdle; FIFO empty; link_o.v = 0; link_o.data = 0.
  - gpio_shadow_o = all ones, matching the endpoint's reset value.
  - error_o = 0; idle_o = 1; ready_o = 1 on the first cycle after reset.
- Input buffer:
  - 2-entry FIFO holding {dest_cord, sel, val}, all captured at enqueue.
  - ready_o = FIFO not full.
  - Enqueue at cycle N makes the entry visible to the FSM at N+1.
- Header flit:
  - data[cord_width_p-1:0] = dest_cord.
  - data[cord_width_p +: len_width_p] = 1 (one payload flit).
  - All other bits 0.
- Payload flit:
  - data[lg_num_gpio_lp-1:0] = sel.
  - data[flit_width_p-1] = val.
  - All other bits 0.
- FSM states eIdle, eHeader, ePayload:
  - eIdle, FIFO empty: stay.
  - eIdle, head entry has sel >= num_gpio_p: dequeue, set error_o, stay in eIdle, no flits sent.
  - eIdle, skip_redundant_p=1 and shadow[sel]==val: dequeue, stay in eIdle, no flits sent.
  - eIdle, otherwise: go to eHeader.
  - eHeader: link_o.v=1 with header data. On link_i.ready_and_rev go to ePayload; otherwise hold v and data stable.
  - ePayload: link_o.v=1 with payload data. On handshake: dequeue, shadow[sel] <= val, go to eIdle.
- link_o.v is 0 in eIdle.
- Latency: request at cycle 0 with downstream always ready gives header at cycle 2 and payload at cycle 3. The shadow updates at the rising edge ending cycle 3. Throughput is one write per 3 cycles.
- Backpressure: any number of stall cycles are allowed in eHeader and ePayload. Once a header has been sent, its payload is always sent next; packets are never interleaved.
- Simultaneous enqueue and dequeue in the same cycle is legal. FIFO order is preserved.
- Reset mid-packet: everything returns to reset values and the partial packet is abandoned. The downstream endpoint shares the same reset, so this is safe.
- Redundant-skip compares against the shadow, which reflects only completed packets. Two queued writes to the same sel are evaluated sequentially.

Decomposition:
- Shared package (bsg_util_link_pkg) holds:
  - header/payload flit field offset constants;
  - packed struct for the GPIO request {dest_cord, sel, val};
  - FSM state enum.
- Input buffer uses bsg_two_fifo.
- Shadow register uses bsg_dff_reset_en with reset_val_p of all ones.
- No new sub-module needed.

Test Plan:
- flit_width_p=16, num_gpio_p=8, cord_width_p=4, len_width_p=4; one request dest=3, sel=5, val=0; downstream always ready -> cycle 2 header 16'h0013, cycle 3 payload 16'h0005, then gpio_shadow_o=8'hDF, idle_o=1.
- Same request, downstream ready low for 4 cycles during eHeader and 3 during ePayload -> link_o.v and data held stable during stalls, exactly 2 handshakes, shadow updates only after the payload handshake.
- skip_redundant_p=1: write sel=2, val=1 just after reset -> no flits, shadow stays 8'hFF. Then sel=2, val=0 -> payload 16'h0002, shadow=8'hFB.
- num_gpio_p=6: request sel=7 -> no flits, error_o=1 and stays set; next valid request sel=1, val=0 is still sent normally.
- Back-to-back requests (sel0/v0, sel1/v0, sel2/v0) with v_i held high -> ready_o drops when the FIFO is full, 6 flits sent in order, final shadow 8'hF8.
- Assert reset_i in ePayload during a stall -> next cycle link_o.v=0, shadow=8'hFF, FIFO empty; a new request afterwards is sent correctly.
